// File: rtl/des_dec_key_scheduler_if.sv
//============================================================================
// Module      : des_dec_key_scheduler_if
// Description : Key-load and subkey-stream handshake bundle for the DES
//               decryption key scheduler.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface des_dec_key_scheduler_if;
    logic        start;
    logic [28:1] key_l;
    logic [28:1] key_r;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [48:1] subkey;
    logic [5:1]  subkey_idx;
    logic        done;

    // Controller / subkey consumer side
    modport master (
        output start, key_l, key_r, subkey_ready,
        input  busy, subkey_valid, subkey, subkey_idx, done
    );

    // Scheduler side
    modport slave (
        input  start, key_l, key_r, subkey_ready,
        output busy, subkey_valid, subkey, subkey_idx, done
    );
endinterface

`default_nettype wire

// File: rtl/des_dec_key_scheduler.sv
//============================================================================
// Module      : des_dec_key_scheduler
// Description : Streams DES round subkeys K16..K1 for decryption by
//               right-rotating the post-PC-1 halves, with valid/ready output.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module des_dec_key_scheduler (
    input  logic                   clk,
    input  logic                   rst_n,
    des_dec_key_scheduler_if.slave kif
);

    // PC-2 selection: subkey bit i takes bit PC2[i-1] of {cur_r, cur_l}
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [28:1] cur_l;
    logic [28:1] cur_r;
    logic [3:0]  cnt;
    logic        r_busy;
    logic        r_valid;
    logic        r_done;
    logic [5:1]  r_idx;

    logic        w_hs;
    logic        w_rot1;
    logic [28:1] w_next_l;
    logic [28:1] w_next_r;
    logic [56:1] w_cd;
    logic [48:1] w_subkey;

    assign w_hs = r_valid & kif.subkey_ready;

    // Single-step rotations precede K15, K8, K1 and the final return to C0/D0
    assign w_rot1 = (cnt == 4'd0) || (cnt == 4'd7) || (cnt == 4'd14) || (cnt == 4'd15);

    assign w_next_l = w_rot1 ? {cur_l[1], cur_l[28:2]} : {cur_l[2:1], cur_l[28:3]};
    assign w_next_r = w_rot1 ? {cur_r[1], cur_r[28:2]} : {cur_r[2:1], cur_r[28:3]};

    assign w_cd = {cur_r, cur_l};

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign w_subkey[g+1] = w_cd[PC2[g]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_l   <= '0;
            cur_r   <= '0;
            cnt     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (state)
                IDLE: begin
                    // C16/D16 equal C0/D0, so K16 needs no rotation on load
                    if (kif.start) begin
                        cur_l   <= kif.key_l;
                        cur_r   <= kif.key_r;
                        cnt     <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_idx   <= 5'd16;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        cur_l <= w_next_l;
                        cur_r <= w_next_r;
                        if (cnt == 4'd15) begin
                            cnt     <= '0;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                            state   <= IDLE;
                        end else begin
                            cnt   <= cnt + 4'd1;
                            r_idx <= 5'd15 - {1'b0, cnt};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kif.busy         = r_busy;
    assign kif.subkey_valid = r_valid;
    assign kif.done         = r_done;
    assign kif.subkey_idx   = r_idx;
    assign kif.subkey       = w_subkey;

endmodule

`default_nettype wire

// File: tb/tb_des_dec_key_scheduler.sv
//============================================================================
// Module      : tb_des_dec_key_scheduler
// Description : Directed self-checking bench for des_dec_key_scheduler,
//               comparing against an encrypt-direction key chain model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_des_dec_key_scheduler;

    localparam int PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int CYCLE_LIMIT = 400;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    des_dec_key_scheduler_if kif();

    des_dec_key_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encrypt-direction rotation (inverse of the decrypt-side right rotation)
    function automatic logic [28:1] rotl(input logic [28:1] x, input int n);
        logic [28:1] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[27:1], y[28]};
        return y;
    endfunction

    function automatic logic [48:1] pc2(input logic [28:1] c, input logic [28:1] d);
        logic [56:1] cd;
        logic [48:1] k;
        cd = {d, c};
        for (int i = 1; i <= 48; i++) k[i] = cd[PC2_TAB[i-1]];
        return k;
    endfunction

    // Starts a sequence and follows it to the done pulse, checking every cycle.
    task automatic run_sequence(input logic [28:1] c0, input logic [28:1] d0,
                                input bit rnd_ready, input bit poke_start,
                                input bit use_const, input logic [48:1] const_k,
                                input bit check_cur);
        logic [48:1] kexp [1:16];
        logic [28:1] cexp [0:16];
        logic [28:1] c;
        logic [28:1] d;
        logic [48:1] exp_k;
        int          n;
        int          cycles;
        bit          r;
        c = c0;
        d = d0;
        cexp[0] = c0;
        for (int i = 1; i <= 16; i++) begin
            c = rotl(c, SHIFTS[i]);
            d = rotl(d, SHIFTS[i]);
            cexp[i] = c;
            kexp[i] = pc2(c, d);
        end
        kif.key_l = c0;
        kif.key_r = d0;
        kif.start = 1'b1;
        @(posedge clk); #1;
        kif.start = 1'b0;
        n = 16;
        cycles = 0;
        while (n >= 1 && cycles < CYCLE_LIMIT) begin
            checks++;
            if (kif.subkey_valid !== 1'b1 || kif.busy !== 1'b1 || kif.done !== 1'b0) begin
                errors++;
                $display("FAIL seq_status idx=%0d: valid/busy/done got %b%b%b want 110",
                         n, kif.subkey_valid, kif.busy, kif.done);
            end
            checks++;
            if (kif.subkey_idx !== 5'(n)) begin
                errors++;
                $display("FAIL seq_idx: got %0d want %0d", kif.subkey_idx, n);
            end
            exp_k = use_const ? const_k : kexp[n];
            checks++;
            if (kif.subkey !== exp_k) begin
                errors++;
                $display("FAIL seq_subkey idx=%0d: got %h want %h", n, kif.subkey, exp_k);
            end
            r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            kif.subkey_ready = r;
            if (poke_start && (n == 10 || n == 1)) begin
                kif.start = 1'b1;
                kif.key_l = ~c0;
                kif.key_r = ~d0;
            end else begin
                kif.start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (r) begin
                if (check_cur) begin
                    checks++;
                    if (dut.cur_l !== cexp[n-1]) begin
                        errors++;
                        $display("FAIL cur_l after idx=%0d: got %h want %h", n, dut.cur_l, cexp[n-1]);
                    end
                end
                n--;
            end
        end
        kif.start = 1'b0;
        kif.subkey_ready = 1'b0;
        if (n >= 1) begin
            checks++;
            errors++;
            $display("FAIL seq_timeout: stuck at idx %0d after %0d cycles want done", n, cycles);
        end
        checks++;
        if (kif.done !== 1'b1 || kif.subkey_valid !== 1'b0 || kif.busy !== 1'b0) begin
            errors++;
            $display("FAIL seq_end: done/valid/busy got %b%b%b want 100",
                     kif.done, kif.subkey_valid, kif.busy);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (kif.busy !== 1'b0 || kif.subkey_valid !== 1'b0 || kif.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/valid/done got %b%b%b want 000",
                     kif.busy, kif.subkey_valid, kif.done);
        end
        checks++;
        if (kif.subkey_idx !== 5'd0 || kif.subkey !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: idx=%0d subkey=%h want 0 and 0", kif.subkey_idx, kif.subkey);
        end
        rst_n = 1'b1;
        kif.subkey_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (kif.subkey_valid !== 1'b0 || kif.subkey_idx !== 5'd0 || dut.cnt !== 4'd0) begin
            errors++;
            $display("FAIL idle_ready: valid=%b idx=%0d cnt=%0d want 0 0 0",
                     kif.subkey_valid, kif.subkey_idx, dut.cnt);
        end
        kif.subkey_ready = 1'b0;
    endtask

    task automatic test_ready_high;
        run_sequence(28'h9A3_5C71, 28'h0F1_E2D3, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (kif.done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b want 0", kif.done);
        end
        run_sequence(28'($urandom), 28'($urandom), 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    endtask

    task automatic test_zero_ones;
        run_sequence(28'h0, 28'h0, 1'b0, 1'b0, 1'b1, 48'h0, 1'b0);
        run_sequence(28'hFFF_FFFF, 28'hFFF_FFFF, 1'b0, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0);
    endtask

    task automatic test_backpressure;
        run_sequence(28'h123_4567, 28'h89A_BCDE, 1'b1, 1'b0, 1'b0, 48'h0, 1'b1);
        run_sequence(28'($urandom), 28'($urandom), 1'b1, 1'b0, 1'b0, 48'h0, 1'b0);
    endtask

    // Start pokes at idx 10 and in the done cycle, then a back-to-back restart
    task automatic test_back_to_back;
        run_sequence(28'h5A5_A5A5, 28'h3C3_C3C3, 1'b0, 1'b1, 1'b0, 48'h0, 1'b0);
        run_sequence(28'h0DE_ADBE, 28'hEF0_1234, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    endtask

    task automatic test_reset_mid;
        kif.key_l = 28'hCAF_EBAB;
        kif.key_r = 28'h765_4321;
        kif.start = 1'b1;
        @(posedge clk); #1;
        kif.start = 1'b0;
        kif.subkey_ready = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        kif.subkey_ready = 1'b0;
        checks++;
        if (kif.subkey_idx !== 5'd7) begin
            errors++;
            $display("FAIL mid_idx: got %0d want 7", kif.subkey_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (kif.subkey_valid !== 1'b0 || kif.busy !== 1'b0 || kif.subkey_idx !== 5'd0 ||
            kif.subkey !== 48'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b idx=%0d subkey=%h want all 0",
                     kif.subkey_valid, kif.busy, kif.subkey_idx, kif.subkey);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_sequence(28'hCAF_EBAB, 28'h765_4321, 1'b0, 1'b0, 1'b0, 48'h0, 1'b0);
    endtask

    task automatic test_rotation;
        run_sequence(28'h000_0001, 28'h0, 1'b0, 1'b0, 1'b0, 48'h0, 1'b1);
        checks++;
        if (dut.cur_l !== 28'h000_0001 || dut.cur_r !== 28'h0) begin
            errors++;
            $display("FAIL rot_final: cur_l=%h cur_r=%h want 0000001 0000000", dut.cur_l, dut.cur_r);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        kif.start = 1'b0;
        kif.key_l = '0;
        kif.key_r = '0;
        kif.subkey_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ready_high();
        test_zero_ones();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_rotation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
